sparse_mac_operand_packer: RTL and testbench
============================================

# sparse_mac_operand_packer

Sequential packing stage wrapped around the small-buffer combinational library: pop count, mask accumulator, mask filter and buffer update. Per compression window it accepts one bitmask/mutual-bitmask header, then consumes the compressed transfer blocks of that window. It keeps only the clusters whose dense position is set in the mutual bitmask and packs them into dense TRANSFER_SIZE-lane MAC operand beats. It sits between the compressed operand stream and the MAC array, owning the leftover buffer, block counter and window framing.

## Interface
- TRANSFER_SIZE, 2, clusters per transfer block and per output beat
- CLUSTER_BITWIDTH, 16, bits per cluster
- COMPRESSION_WINDOW_SIZE, 8, dense positions per window; multiple of TRANSFER_SIZE
- Derived: COUNT_W = clog2(TRANSFER_SIZE+1)

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- i_mask_valid  in  1  header valid
- i_mask_ready  out  1  header accepted when valid&&ready
- i_bitmask  in  COMPRESSION_WINDOW_SIZE  nonzero map; bit d = dense position d
- i_mutual_bitmask  in  COMPRESSION_WINDOW_SIZE  positions to keep
- i_block_valid  in  1  transfer block valid
- i_block_ready  out  1  block accepted when valid&&ready
- i_block_data  in  TRANSFER_SIZE*CLUSTER_BITWIDTH  lane j = bits [j*CB +: CB]
- o_valid  out  1  operand beat valid
- i_ready  in  1  downstream accepts beat
- o_operands  out  TRANSFER_SIZE*CLUSTER_BITWIDTH  packed clusters, lane 0 first
- o_count  out  COUNT_W  valid lanes in beat (0..TRANSFER_SIZE)
- o_last  out  1  final beat of window

## Operation
- States: IDLE, STREAM, FLUSH.
- IDLE: i_mask_ready=1. On header accept, latch:
  - bitmask B;
  - keep mask K = mutual & B; mutual bits outside B are ignored;
  - P = popcount(B);
  - N = ceil(P/TRANSFER_SIZE).
  - Clear the block counter k.
  - Next state is STREAM if P>0, else FLUSH.
- STREAM, per accepted block k:
  - Compressed lane j maps to c = k*TS+j.
  - Lanes with c≥P are ignored, whatever their data.
  - Otherwise d = dense position of the (c+1)-th set bit of B, and the lane is kept iff K[d].
  - Kept clusters are appended, in lane order, after the buffer contents (0..TS-1 clusters).
  - Let total = buffer + kept (≤2TS-1).
- Non-last block (k<N-1):
  - if total≥TS, emit the first TS clusters with count=TS and last=0; the remainder becomes the buffer;
  - else all clusters go to the buffer and no beat is emitted.
- Last block (k=N-1):
  - if total≤TS, emit all clusters with count=total and last=1, clear the buffer, go to IDLE; count may be 0;
  - if total>TS, emit TS clusters with last=0, keep the remainder, go to FLUSH.
- FLUSH: emit the buffer with count=size and last=1 (count 0 if P=0), clear the buffer, go to IDLE.
- Framing: every window produces exactly one last=1 beat.
- Unused lanes (≥count) drive zero.
- i_block_ready = (state==STREAM) && (!o_valid || i_ready). Blocks are never accepted in IDLE or FLUSH.

## Timing
- All outputs are registered. Reset values:
  - o_valid=0, o_operands=0, o_count=0, o_last=0;
  - i_mask_ready=1 (IDLE), i_block_ready=0;
  - buffer and counters cleared.
- Header accepted in cycle t → STREAM or FLUSH at t+1.
- Block accepted in cycle t → beat visible on the outputs at t+1. Throughput is one block per cycle.
- FLUSH loads its beat when (!o_valid || i_ready), then returns to IDLE the next cycle.
- Window overhead: 1 header cycle, plus 1 cycle if FLUSH is used.
- Backpressure: while o_valid && !i_ready, the beat holds stable and no block or flush loads.
- A simultaneous i_ready and block accept replaces the beat in the same edge with no bubble.
- Reset mid-window discards all partial state; upstream resets with it.

## Test plan
Defaults TS=2, CB=16, W=8. Blocks are written {lane0,lane1}.
- B=0xF6, M=0x66; blocks {A0,A1},{A2,A3},{A4,A5} → beats {A0,A1} c2 last0, then {A3,A4} c2 last1. Exactly 3 blocks accepted.
- B=0x00, M=0xFF → i_block_ready never asserts; one beat c0 last1, operands 0; back to IDLE.
- B=0xFF, M=0xFE; blocks {A0,A1}..{A6,A7} → {A1,A2}, {A3,A4}, {A5,A6} each last0, then FLUSH {A7,0} c1 last1.
- B=0x1F, M=0x1D; third block {A4,0xDEAD} → {A0,A2} last0, {A3,A4} last1. The 0xDEAD lane is ignored.
- Repeat the first case with i_ready=0 for 5 cycles after the first beat → beat holds stable and i_block_ready=0; the sequence resumes unchanged.
- Assert resetn low after the first block of a window → all outputs at reset values immediately. A fresh header then packs correctly with no stale buffer contents.

Source files
------------

// File: rtl/sparse_mac_operand_packer.sv
// -----------------------------------------------------------------------------
// sparse_mac_operand_packer
//
// Sits between a compressed operand stream and the MAC array. For every
// compression window it takes one header (bitmask B + mutual bitmask M), then
// consumes ceil(popcount(B)/TRANSFER_SIZE) compressed transfer blocks. Each
// compressed lane is mapped back to its dense position; only clusters whose
// dense position is set in (M & B) survive. Survivors are packed, in order,
// into dense TRANSFER_SIZE-lane beats. Every window ends with exactly one
// beat carrying o_last=1 (possibly with o_count=0).
//
// Ports:
//   clock, resetn        clock (rising edge), asynchronous active-low reset
//   i_mask_valid/ready   header handshake (ready only while idle)
//   i_bitmask            nonzero map of the window, bit d = dense position d
//   i_mutual_bitmask     dense positions to keep
//   i_block_valid/ready  compressed transfer block handshake
//   i_block_data         lane j = bits [j*CLUSTER_BITWIDTH +: CLUSTER_BITWIDTH]
//   o_valid / i_ready    operand beat handshake
//   o_operands           packed clusters, lane 0 first, unused lanes zero
//   o_count              number of valid lanes in the beat
//   o_last               final beat of the window
// -----------------------------------------------------------------------------
module sparse_mac_operand_packer #(
  parameter int TRANSFER_SIZE           = 2,
  parameter int CLUSTER_BITWIDTH        = 16,
  parameter int COMPRESSION_WINDOW_SIZE = 8,
  localparam int COUNT_W                = $clog2(TRANSFER_SIZE + 1)
) (
  input  logic                                         clock,
  input  logic                                         resetn,
  input  logic                                         i_mask_valid,
  output logic                                         i_mask_ready,
  input  logic [COMPRESSION_WINDOW_SIZE-1:0]           i_bitmask,
  input  logic [COMPRESSION_WINDOW_SIZE-1:0]           i_mutual_bitmask,
  input  logic                                         i_block_valid,
  output logic                                         i_block_ready,
  input  logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0]    i_block_data,
  output logic                                         o_valid,
  input  logic                                         i_ready,
  output logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0]    o_operands,
  output logic [COUNT_W-1:0]                           o_count,
  output logic                                         o_last
);

  localparam int TS   = TRANSFER_SIZE;
  localparam int CB   = CLUSTER_BITWIDTH;
  localparam int W    = COMPRESSION_WINDOW_SIZE;
  localparam int DW   = TS * CB;
  localparam int PW   = $clog2(W + 1);        // popcount width
  localparam int NBLK = W / TS;               // max blocks per window
  localparam int KW   = $clog2(NBLK + 1);     // block counter width
  localparam int IW   = $clog2(2 * TS);       // holds 0 .. 2*TS-1 (buffer + kept)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // Number of set bits in a window map.
  function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
    logic [PW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(v[i]);
    end
    return cnt;
  endfunction

  // Keep bit of the dense position holding the (rank+1)-th set bit of b.
  function automatic logic keep_at_rank(input logic [W-1:0] b,
                                        input logic [W-1:0] k,
                                        input int           rank);
    int   seen;
    logic hit;
    seen = 0;
    hit  = 1'b0;
    for (int d = 0; d < W; d++) begin
      if (b[d]) begin
        if (seen == rank) begin
          hit = k[d];
        end else begin
          hit = hit;
        end
        seen = seen + 1;
      end else begin
        seen = seen;
      end
    end
    return hit;
  endfunction

  state_e                 state_q, state_d;
  logic [W-1:0]           bitmask_q, bitmask_d;
  logic [W-1:0]           keep_q, keep_d;
  logic [PW-1:0]          pop_q, pop_d;
  logic [KW-1:0]          nblk_q, nblk_d;
  logic [KW-1:0]          blk_q, blk_d;
  logic [TS-1:0][CB-1:0]  buf_q, buf_d;       // lanes >= buf_cnt_q are kept zero
  logic [IW-1:0]          buf_cnt_q, buf_cnt_d;
  logic                   valid_q, valid_d;
  logic [DW-1:0]          ops_q, ops_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   last_q, last_d;

  logic [PW-1:0]          hdr_pop_s;
  logic [TS-1:0]          lane_keep_s;
  logic [2*TS-1:0][CB-1:0] merged_s;
  logic [IW-1:0]          wr_idx_s;
  logic [IW-1:0]          total_s;
  logic                   out_free_s;
  logic                   block_ready_s;
  logic                   blk_fire_s;
  logic                   last_blk_s;

  assign hdr_pop_s     = popcount(i_bitmask);
  assign out_free_s    = !valid_q || i_ready;
  assign block_ready_s = (state_q == ST_STREAM) && out_free_s;
  assign blk_fire_s    = i_block_valid && block_ready_s;
  assign last_blk_s    = ((blk_q + KW'(1'b1)) == nblk_q);

  // Decide per compressed lane whether it is in range and survives the keep mask.
  always_comb begin
    lane_keep_s = '0;
    for (int j = 0; j < TS; j++) begin
      if ((int'(blk_q) * TS + j) < int'(pop_q)) begin
        lane_keep_s[j] = keep_at_rank(bitmask_q, keep_q, int'(blk_q) * TS + j);
      end else begin
        lane_keep_s[j] = 1'b0;
      end
    end
  end

  // Append kept lanes after the leftover buffer; total never exceeds 2*TS-1.
  always_comb begin
    merged_s          = '0;
    merged_s[TS-1:0]  = buf_q;
    wr_idx_s          = buf_cnt_q;
    for (int j = 0; j < TS; j++) begin
      if (lane_keep_s[j]) begin
        merged_s[wr_idx_s] = i_block_data[j*CB +: CB];
        wr_idx_s           = wr_idx_s + IW'(1'b1);
      end else begin
        wr_idx_s = wr_idx_s;
      end
    end
    total_s = wr_idx_s;
  end

  // Window framing FSM plus beat/buffer next-state.
  always_comb begin
    state_d   = state_q;
    bitmask_d = bitmask_q;
    keep_d    = keep_q;
    pop_d     = pop_q;
    nblk_d    = nblk_q;
    blk_d     = blk_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    ops_d     = ops_q;
    count_d   = count_q;
    last_d    = last_q;
    // A consumed beat drops valid unless a new beat is loaded below.
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_mask_valid) begin
          bitmask_d = i_bitmask;
          keep_d    = i_bitmask & i_mutual_bitmask;
          pop_d     = hdr_pop_s;
          nblk_d    = KW'((int'(hdr_pop_s) + TS - 1) / TS);
          blk_d     = '0;
          buf_d     = '0;
          buf_cnt_d = '0;
          state_d   = (hdr_pop_s != '0) ? ST_STREAM : ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        if (blk_fire_s) begin
          blk_d = blk_q + KW'(1'b1);
          if (last_blk_s) begin
            if (total_s <= IW'(TS)) begin
              // Everything fits into the closing beat (count may be 0).
              valid_d   = 1'b1;
              ops_d     = merged_s[TS-1:0];
              count_d   = COUNT_W'(total_s);
              last_d    = 1'b1;
              buf_d     = '0;
              buf_cnt_d = '0;
              state_d   = ST_IDLE;
            end else begin
              // One full beat now, the remainder closes the window in FLUSH.
              valid_d   = 1'b1;
              ops_d     = merged_s[TS-1:0];
              count_d   = COUNT_W'(TS);
              last_d    = 1'b0;
              buf_d     = merged_s[2*TS-1:TS];
              buf_cnt_d = total_s - IW'(TS);
              state_d   = ST_FLUSH;
            end
          end else begin
            if (total_s >= IW'(TS)) begin
              valid_d   = 1'b1;
              ops_d     = merged_s[TS-1:0];
              count_d   = COUNT_W'(TS);
              last_d    = 1'b0;
              buf_d     = merged_s[2*TS-1:TS];
              buf_cnt_d = total_s - IW'(TS);
            end else begin
              buf_d     = merged_s[TS-1:0];
              buf_cnt_d = total_s;
            end
          end
        end else begin
          state_d = ST_STREAM;
        end
      end

      ST_FLUSH: begin
        if (out_free_s) begin
          valid_d   = 1'b1;
          ops_d     = buf_q;
          count_d   = COUNT_W'(buf_cnt_q);
          last_d    = 1'b1;
          buf_d     = '0;
          buf_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, window context, leftover buffer and output beat registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bitmask_q <= '0;
      keep_q    <= '0;
      pop_q     <= '0;
      nblk_q    <= '0;
      blk_q     <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      valid_q   <= 1'b0;
      ops_q     <= '0;
      count_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitmask_q <= bitmask_d;
      keep_q    <= keep_d;
      pop_q     <= pop_d;
      nblk_q    <= nblk_d;
      blk_q     <= blk_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      valid_q   <= valid_d;
      ops_q     <= ops_d;
      count_q   <= count_d;
      last_q    <= last_d;
    end
  end

  assign i_mask_ready  = (state_q == ST_IDLE);
  assign i_block_ready = block_ready_s;
  assign o_valid       = valid_q;
  assign o_operands    = ops_q;
  assign o_count       = count_q;
  assign o_last        = last_q;

endmodule

// File: tb/tb_sparse_mac_operand_packer.sv
module tb_sparse_mac_operand_packer;

  localparam int TS      = 2;
  localparam int CB      = 16;
  localparam int W       = 8;
  localparam int COUNT_W = $clog2(TS + 1);
  localparam int DW      = TS * CB;
  localparam int NB      = W / TS;
  localparam int NV      = 6;

  logic               clock = 1'b0;
  logic               resetn;
  logic               i_mask_valid;
  logic               i_mask_ready;
  logic [W-1:0]       i_bitmask;
  logic [W-1:0]       i_mutual_bitmask;
  logic               i_block_valid;
  logic               i_block_ready;
  logic [DW-1:0]      i_block_data;
  logic               o_valid;
  logic               i_ready;
  logic [DW-1:0]      o_operands;
  logic [COUNT_W-1:0] o_count;
  logic               o_last;

  sparse_mac_operand_packer #(
    .TRANSFER_SIZE(TS), .CLUSTER_BITWIDTH(CB), .COMPRESSION_WINDOW_SIZE(W)
  ) dut (
    .clock(clock), .resetn(resetn),
    .i_mask_valid(i_mask_valid), .i_mask_ready(i_mask_ready),
    .i_bitmask(i_bitmask), .i_mutual_bitmask(i_mutual_bitmask),
    .i_block_valid(i_block_valid), .i_block_ready(i_block_ready),
    .i_block_data(i_block_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_operands(o_operands), .o_count(o_count), .o_last(o_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0]      ops;
    logic [COUNT_W-1:0] cnt;
    logic               last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]                  b;
    logic [W-1:0]                  m;
    logic [3:0]                    nblk;
    logic [NB-1:0][DW-1:0]         blk;
    logic [3:0]                    nbeats;
    logic [NB:0][DW-1:0]           ops;
    logic [NB:0][COUNT_W-1:0]      cnt;
    logic [NB:0]                   last;
  } vec_t;

  vec_t                  vt [NV];
  beat_t                 exp_q [$];
  logic [CB-1:0]         mq [$];
  logic [W-1:0]          cur_b, cur_m;
  logic [NB-1:0][DW-1:0] cur_blk;
  int                    cur_nblk;
  int                    checks = 0;
  int                    failures = 0;

  function automatic logic [CB-1:0] A(input int n);
    return 16'hA000 + 16'(n);
  endfunction

  function automatic logic [CB-1:0] Bv(input int n);
    return 16'hB000 + 16'(n);
  endfunction

  function automatic logic [DW-1:0] blk2(input logic [CB-1:0] l0, input logic [CB-1:0] l1);
    return {l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_beat(input int v, input int i, input logic [DW-1:0] ops,
                          input int cnt, input logic lst);
    vt[v].ops[i]  = ops;
    vt[v].cnt[i]  = COUNT_W'(cnt);
    vt[v].last[i] = lst;
  endtask

  // Reference model: walk the dense positions, collect kept clusters per block
  // into a queue and cut beats by the framing rules.
  function automatic int nth_set(input logic [W-1:0] b, input int r);
    int left;
    left = r;
    for (int d = 0; d < W; d++) begin
      if (b[d]) begin
        if (left == 0) return d;
        left--;
      end
    end
    return -1;
  endfunction

  function automatic void emit(input int n, input logic lst);
    beat_t e;
    e.ops = '0;
    for (int i = 0; i < n; i++) e.ops[i*CB +: CB] = mq.pop_front();
    e.cnt  = COUNT_W'(n);
    e.last = lst;
    exp_q.push_back(e);
  endfunction

  function automatic void model_window();
    int p, n, c, d;
    mq.delete();
    exp_q.delete();
    p = $countones(cur_b);
    n = (p + TS - 1) / TS;
    cur_nblk = n;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < TS; j++) begin
        c = k * TS + j;
        if (c < p) begin
          d = nth_set(cur_b, c);
          if (cur_m[d]) mq.push_back(cur_blk[k][j*CB +: CB]);
        end
      end
      if (k < n - 1) begin
        if (mq.size() >= TS) emit(TS, 1'b0);
      end else if (mq.size() <= TS) begin
        emit(mq.size(), 1'b1);
      end else begin
        emit(TS, 1'b0);
        emit(mq.size(), 1'b1);
      end
    end
    if (n == 0) emit(0, 1'b1);
  endfunction

  // Drive one window (header + cur_nblk blocks) and score beats against exp_q.
  task automatic run_window(input int vpct, input int rpct, input string tag);
    int    bi;
    bit    hdr_done;
    int    cyc;
    beat_t e;
    bi = 0; hdr_done = 0; cyc = 0;
    i_bitmask = cur_b;
    i_mutual_bitmask = cur_m;
    while (!(hdr_done && bi == cur_nblk && exp_q.size() == 0) && cyc < 400) begin
      i_mask_valid  = !hdr_done;
      i_block_valid = hdr_done && (bi < cur_nblk) && ($urandom_range(99) < vpct);
      i_block_data  = (bi < cur_nblk) ? cur_blk[bi] : '0;
      i_ready       = ($urandom_range(99) < rpct);
      #1;
      if (!hdr_done || bi == cur_nblk) chk({tag, "_blk_ready_off"}, 64'(i_block_ready), 64'd0);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_beat"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_ops"},  64'(o_operands), 64'(e.ops));
          chk({tag, "_cnt"},  64'(o_count),    64'(e.cnt));
          chk({tag, "_last"}, 64'(o_last),     64'(e.last));
        end
      end
      if (i_block_valid && i_block_ready) bi++;
      if (i_mask_valid && i_mask_ready) hdr_done = 1;
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 400) chk({tag, "_timeout_beats_left"}, 64'(exp_q.size()), 64'd0);
    i_mask_valid  = 1'b0;
    i_block_valid = 1'b0;
    i_ready       = 1'b1;
  endtask

  task automatic load_vec(input int v);
    beat_t e;
    cur_b = vt[v].b; cur_m = vt[v].m; cur_blk = vt[v].blk; cur_nblk = int'(vt[v].nblk);
    exp_q.delete();
    for (int i = 0; i < int'(vt[v].nbeats); i++) begin
      e.ops = vt[v].ops[i]; e.cnt = vt[v].cnt[i]; e.last = vt[v].last[i];
      exp_q.push_back(e);
    end
  endtask

  initial begin
    // Directed vectors: {B, M, blocks} -> expected beats.
    for (int v = 0; v < NV; v++) vt[v] = '0;
    vt[0].b = 8'hF6; vt[0].m = 8'h66; vt[0].nblk = 4'd3; vt[0].nbeats = 4'd2;
    vt[0].blk[0] = blk2(A(0), A(1)); vt[0].blk[1] = blk2(A(2), A(3)); vt[0].blk[2] = blk2(A(4), A(5));
    set_beat(0, 0, blk2(A(0), A(1)), 2, 1'b0);
    set_beat(0, 1, blk2(A(3), A(4)), 2, 1'b1);
    vt[1].b = 8'h00; vt[1].m = 8'hFF; vt[1].nblk = 4'd0; vt[1].nbeats = 4'd1;
    set_beat(1, 0, '0, 0, 1'b1);
    vt[2].b = 8'hFF; vt[2].m = 8'hFE; vt[2].nblk = 4'd4; vt[2].nbeats = 4'd4;
    for (int k = 0; k < 4; k++) vt[2].blk[k] = blk2(A(2*k), A(2*k+1));
    set_beat(2, 0, blk2(A(1), A(2)), 2, 1'b0);
    set_beat(2, 1, blk2(A(3), A(4)), 2, 1'b0);
    set_beat(2, 2, blk2(A(5), A(6)), 2, 1'b0);
    set_beat(2, 3, blk2(A(7), 16'h0000), 1, 1'b1);
    vt[3].b = 8'h1F; vt[3].m = 8'h1D; vt[3].nblk = 4'd3; vt[3].nbeats = 4'd2;
    vt[3].blk[0] = blk2(A(0), A(1)); vt[3].blk[1] = blk2(A(2), A(3)); vt[3].blk[2] = blk2(A(4), 16'hDEAD);
    set_beat(3, 0, blk2(A(0), A(2)), 2, 1'b0);
    set_beat(3, 1, blk2(A(3), A(4)), 2, 1'b1);
    vt[4].b = 8'hFF; vt[4].m = 8'h03; vt[4].nblk = 4'd4; vt[4].nbeats = 4'd2;
    for (int k = 0; k < 4; k++) vt[4].blk[k] = blk2(A(2*k), A(2*k+1));
    set_beat(4, 0, blk2(A(0), A(1)), 2, 1'b0);
    set_beat(4, 1, '0, 0, 1'b1);
    vt[5].b = 8'h81; vt[5].m = 8'h80; vt[5].nblk = 4'd1; vt[5].nbeats = 4'd1;
    vt[5].blk[0] = blk2(A(0), A(1));
    set_beat(5, 0, blk2(A(1), 16'h0000), 1, 1'b1);

    // Reset state.
    resetn = 1'b0; i_mask_valid = 1'b0; i_bitmask = '0; i_mutual_bitmask = '0;
    i_block_valid = 1'b0; i_block_data = '0; i_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ops", 64'(o_operands), 64'd0);
    chk("rst_cnt", 64'(o_count), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_mask_ready", 64'(i_mask_ready), 64'd1);
    chk("rst_blk_ready", 64'(i_block_ready), 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      run_window(100, 100, $sformatf("vec%0d", v));
    end

    // Latency and backpressure on the first directed window.
    i_bitmask = 8'hF6; i_mutual_bitmask = 8'h66; i_mask_valid = 1'b1; i_ready = 1'b1;
    #1; chk("bp_hdr_ready", 64'(i_mask_ready), 64'd1);
    @(posedge clock); #1;
    i_mask_valid = 1'b0;
    chk("bp_stream_ready", 64'(i_block_ready), 64'd1);
    i_block_valid = 1'b1; i_block_data = blk2(A(0), A(1));
    @(posedge clock); #1;
    chk("bp_lat_valid", 64'(o_valid), 64'd1);
    chk("bp_lat_ops", 64'(o_operands), 64'(blk2(A(0), A(1))));
    chk("bp_lat_cnt", 64'(o_count), 64'd2);
    chk("bp_lat_last", 64'(o_last), 64'd0);
    i_ready = 1'b0; i_block_data = blk2(A(2), A(3));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_blk_ready", 64'(i_block_ready), 64'd0);
      chk("bp_hold_valid", 64'(o_valid), 64'd1);
      chk("bp_hold_ops", 64'(o_operands), 64'(blk2(A(0), A(1))));
      @(posedge clock); #1;
    end
    i_ready = 1'b1;
    #1; chk("bp_resume_ready", 64'(i_block_ready), 64'd1);
    @(posedge clock); #1;
    chk("bp_no_beat", 64'(o_valid), 64'd0);
    i_block_data = blk2(A(4), A(5));
    @(posedge clock); #1;
    chk("bp_fin_valid", 64'(o_valid), 64'd1);
    chk("bp_fin_ops", 64'(o_operands), 64'(blk2(A(3), A(4))));
    chk("bp_fin_cnt", 64'(o_count), 64'd2);
    chk("bp_fin_last", 64'(o_last), 64'd1);
    i_block_valid = 1'b0;
    @(posedge clock); #1;
    chk("bp_idle_valid", 64'(o_valid), 64'd0);
    chk("bp_idle_mask_ready", 64'(i_mask_ready), 64'd1);
    chk("bp_idle_blk_ready", 64'(i_block_ready), 64'd0);

    // Reset mid-window with a beat pending and a leftover cluster buffered.
    i_bitmask = 8'hFF; i_mutual_bitmask = 8'hFE; i_mask_valid = 1'b1;
    @(posedge clock); #1;
    i_mask_valid = 1'b0; i_block_valid = 1'b1; i_block_data = blk2(Bv(0), Bv(1));
    @(posedge clock); #1;
    i_block_data = blk2(Bv(2), Bv(3));
    @(posedge clock); #1;
    chk("mid_valid", 64'(o_valid), 64'd1);
    i_block_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_ops", 64'(o_operands), 64'd0);
    chk("mid_rst_cnt", 64'(o_count), 64'd0);
    chk("mid_rst_last", 64'(o_last), 64'd0);
    chk("mid_rst_mask_ready", 64'(i_mask_ready), 64'd1);
    chk("mid_rst_blk_ready", 64'(i_block_ready), 64'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    load_vec(0);
    run_window(100, 100, "post_rst");

    // Randomized windows scored against the reference model.
    for (int w = 0; w < 60; w++) begin
      case ($urandom_range(9))
        0:       cur_b = 8'h00;
        1:       cur_b = 8'hFF;
        default: cur_b = W'($urandom);
      endcase
      cur_m = ($urandom_range(4) == 0) ? 8'hFF : W'($urandom);
      for (int k = 0; k < NB; k++) cur_blk[k] = DW'($urandom);
      model_window();
      run_window($urandom_range(100, 40), $urandom_range(100, 30), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
